// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C target core.
//   i2c_state_t          protocol FSM state encoding
//   ACK / NACK           bus level of the 9th (acknowledge) bit
//   DEFAULT_TARGET_ADDR  default 7-bit target address
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } i2c_state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h50;

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: multi-flop synchronizer with rise/fall detection on the
// synchronized level. Flops reset to 1 (idle bus).
//   clk    in  core clock
//   rst    in  synchronous active-high reset
//   din    in  raw asynchronous pad level
//   level  out synchronized level
//   rise   out synchronized level went 0 -> 1 this cycle
//   fall   out synchronized level went 1 -> 0 this cycle
module i2c_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/i2c_target_core.sv
// i2c_target_core: I2C target (slave) protocol engine, single core clock.
// Optional macro: I2C_TARGET_CLK_STRETCH_EN -- stretch SCL on RX overrun /
// TX underrun instead of NACK/0xFF plus an err_o pulse.
//   i2c_core_clk_i  in  core clock (>= 10x SCL)
//   i2c_core_rst_i  in  synchronous active-high reset
//   scl_i, sda_i    in  raw pad levels
//   sda_oe_o        out 1 = pull SDA low
//   scl_oe_o        out 1 = pull SCL low (clock stretch)
//   rx_data_o       out last received byte
//   rx_valid_o      out rx_data_o unread; cleared by rx_ready_i
//   rx_ready_i      in  consumer accepts rx_data_o
//   tx_data_i       in  byte to transmit
//   tx_valid_i      in  tx_data_i available
//   tx_ready_o      out pulse: tx_data_i consumed
//   busy_o          out addressed transaction in progress
//   rw_o            out R/W bit of current transaction (1 = read)
//   err_o           out pulse on RX overrun / TX underrun
module i2c_target_core
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = DEFAULT_TARGET_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i2c_core_clk_i,
    input  logic       i2c_core_rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic       scl_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       busy_o,
    output logic       rw_o,
    output logic       err_o
);

`ifdef I2C_TARGET_CLK_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (i2c_core_clk_i),
        .rst   (i2c_core_rst_i),
        .din   (scl_i),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (i2c_core_clk_i),
        .rst   (i2c_core_rst_i),
        .din   (sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    i2c_state_t state;
    logic [3:0] bit_cnt;
    logic [7:0] shift;     // address / receive shift register
    logic [6:0] tx_rest;   // transmit bits not yet on the bus
    logic       dropped;   // current RX byte could not be stored
    logic       pending;   // stretching while waiting for rx_valid_o to clear
    logic       tx_wait;   // stretching while waiting for tx_valid_i
    logic       got_ack;
    logic       scl_hold;

    logic       start_cond, stop_cond, tx_enter;
    logic [7:0] rx_byte;

    assign start_cond = scl_lvl & sda_fall;
    assign stop_cond  = scl_lvl & sda_rise;
    assign rx_byte    = {shift[6:0], sda_lvl};
    // SCL falling edge that ends an ACK period leading into a transmit byte
    assign tx_enter   = scl_fall && ((state == ADDR_ACK && rw_o) ||
                                     (state == TX_ACK && got_ack));
    assign scl_oe_o   = STRETCH ? scl_hold : 1'b0;

    always_ff @(posedge i2c_core_clk_i) begin
        if (i2c_core_rst_i) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            tx_rest    <= '0;
            dropped    <= 1'b0;
            pending    <= 1'b0;
            tx_wait    <= 1'b0;
            got_ack    <= 1'b0;
            scl_hold   <= 1'b0;
            sda_oe_o   <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            tx_ready_o <= 1'b0;
            busy_o     <= 1'b0;
            rw_o       <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            tx_ready_o <= 1'b0;
            err_o      <= 1'b0;
            // a load later in this block overrides this clear
            if (rx_valid_o && rx_ready_i)
                rx_valid_o <= 1'b0;

            if (stop_cond) begin
                state    <= IDLE;
                sda_oe_o <= 1'b0;
                scl_hold <= 1'b0;
                busy_o   <= 1'b0;
                pending  <= 1'b0;
                tx_wait  <= 1'b0;
            end else if (start_cond) begin
                state    <= ADDR;
                bit_cnt  <= '0;
                sda_oe_o <= 1'b0;
                scl_hold <= 1'b0;
                pending  <= 1'b0;
                tx_wait  <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shift[7:1] == TARGET_ADDR) begin
                                state    <= ADDR_ACK;
                                sda_oe_o <= ~ACK;
                                busy_o   <= 1'b1;
                                rw_o     <= shift[0];
                            end else begin
                                state  <= WAIT_STOP;
                                busy_o <= 1'b0;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            sda_oe_o <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= rw_o ? TX_BYTE : RX_BYTE;
                        end
                    end

                    RX_BYTE: begin
                        if (pending) begin
                            if (!rx_valid_o) begin
                                rx_data_o  <= shift;
                                rx_valid_o <= 1'b1;
                                pending    <= 1'b0;
                                dropped    <= 1'b0;
                                scl_hold   <= 1'b0;
                                sda_oe_o   <= ~ACK;
                                state      <= RX_ACK;
                            end
                        end else if (scl_rise && bit_cnt < 4'd8) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (!rx_valid_o) begin
                                    rx_data_o  <= rx_byte;
                                    rx_valid_o <= 1'b1;
                                    dropped    <= 1'b0;
                                end else begin
                                    dropped <= 1'b1;
                                    if (!STRETCH)
                                        err_o <= 1'b1;
                                end
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (dropped && STRETCH) begin
                                pending  <= 1'b1;
                                scl_hold <= 1'b1;
                            end else begin
                                state    <= RX_ACK;
                                sda_oe_o <= ~dropped;
                            end
                        end
                    end

                    RX_ACK: begin
                        if (scl_fall) begin
                            sda_oe_o <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= dropped ? WAIT_STOP : RX_BYTE;
                        end
                    end

                    TX_BYTE: begin
                        if (tx_wait) begin
                            if (tx_valid_i) begin
                                tx_rest    <= tx_data_i[6:0];
                                sda_oe_o   <= ~tx_data_i[7];
                                tx_ready_o <= 1'b1;
                                tx_wait    <= 1'b0;
                                scl_hold   <= 1'b0;
                            end
                        end else if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe_o <= 1'b0;
                                got_ack  <= 1'b0;
                                state    <= TX_ACK;
                            end else begin
                                sda_oe_o <= ~tx_rest[6];
                                tx_rest  <= {tx_rest[5:0], 1'b0};
                            end
                        end
                    end

                    TX_ACK: begin
                        if (scl_rise) begin
                            if (sda_lvl == ACK)
                                got_ack <= 1'b1;
                            else
                                state <= WAIT_STOP;
                        end else if (scl_fall) begin
                            bit_cnt <= '0;
                            if (got_ack)
                                state <= TX_BYTE;
                        end
                    end

                    default: begin
                    end
                endcase

                // First bit of a transmit byte goes out on the same falling
                // edge that ends the preceding ACK, overriding the release above.
                if (tx_enter) begin
                    if (tx_valid_i) begin
                        tx_rest    <= tx_data_i[6:0];
                        sda_oe_o   <= ~tx_data_i[7];
                        tx_ready_o <= 1'b1;
                    end else if (STRETCH) begin
                        tx_wait  <= 1'b1;
                        scl_hold <= 1'b1;
                        sda_oe_o <= 1'b0;
                    end else begin
                        tx_rest  <= '1;
                        sda_oe_o <= 1'b0;
                        err_o    <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_core.sv
// tb_i2c_target_core: directed testbench for i2c_target_core with an
// open-drain bus model and a bit-level I2C controller.
module tb_i2c_target_core;
    import i2c_pkg::*;

    localparam int Q = 10;  // core clocks per quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_c, sda_c;
    logic       scl_i, sda_i;
    logic       sda_oe_o, scl_oe_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, rx_ready_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i, tx_ready_o;
    logic       busy_o, rw_o, err_o;

    always #5 clk = ~clk;

    assign scl_i = scl_c & ~scl_oe_o;
    assign sda_i = sda_c & ~sda_oe_o;

    i2c_target_core #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .i2c_core_clk_i (clk),
        .i2c_core_rst_i (rst),
        .scl_i          (scl_i),
        .sda_i          (sda_i),
        .sda_oe_o       (sda_oe_o),
        .scl_oe_o       (scl_oe_o),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .rx_ready_i     (rx_ready_i),
        .tx_data_i      (tx_data_i),
        .tx_valid_i     (tx_valid_i),
        .tx_ready_o     (tx_ready_o),
        .busy_o         (busy_o),
        .rw_o           (rw_o),
        .err_o          (err_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // consumer / producer model and event counters
    logic [7:0] rx_seen[$];
    logic [7:0] tx_q[$];
    int rx_valid_cycles = 0;
    int err_pulses      = 0;
    int tx_ready_pulses = 0;
    int busy_cycles     = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid_o) rx_valid_cycles++;
            if (rx_valid_o && rx_ready_i) rx_seen.push_back(rx_data_o);
            if (err_o) err_pulses++;
            if (busy_o) busy_cycles++;
            if (tx_ready_o) begin
                tx_ready_pulses++;
                if (tx_q.size() != 0) tx_q.delete(0);
            end
        end
        tx_valid_i = (tx_q.size() != 0);
        tx_data_i  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_c = 1'b1; scl_c = 1'b1; wait_q();
        sda_c = 1'b0; wait_q();
        scl_c = 1'b0; wait_q();
    endtask

    task automatic i2c_rstart();
        sda_c = 1'b1; wait_q();
        scl_c = 1'b1; wait_q();
        sda_c = 1'b0; wait_q();
        scl_c = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_c = 1'b0; wait_q();
        scl_c = 1'b1; wait_q();
        sda_c = 1'b1; wait_q();
    endtask

    task automatic scl_bit(input logic b, output logic r);
        sda_c = b;
        wait_q();
        scl_c = 1'b1;
        for (int n = 0; n < 4000 && !scl_i; n++) @(negedge clk);
        if (!scl_i) check("scl_release", 32'(scl_i), 32'd1);
        wait_q();
        r = sda_i;
        wait_q();
        scl_c = 1'b0;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) scl_bit(d[i], r);
        scl_bit(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic r;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            scl_bit(1'b1, r);
            d = {d[6:0], r};
        end
        scl_bit(ack, r);
    endtask

    logic       ack;
    logic [7:0] d;
    int         snap;

    initial begin
        rst = 1'b1; scl_c = 1'b1; sda_c = 1'b1; rx_ready_i = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_sda_oe",   32'(sda_oe_o),   32'd0);
        check("rst_scl_oe",   32'(scl_oe_o),   32'd0);
        check("rst_rx_data",  32'(rx_data_o),  32'd0);
        check("rst_rx_valid", 32'(rx_valid_o), 32'd0);
        check("rst_tx_ready", 32'(tx_ready_o), 32'd0);
        check("rst_busy",     32'(busy_o),     32'd0);
        check("rst_rw",       32'(rw_o),       32'd0);
        check("rst_err",      32'(err_o),      32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // write 0x50: 0xA5, 0x3C with consumer always ready
        rx_ready_i = 1'b1;
        rx_seen.delete();
        snap = rx_valid_cycles;
        i2c_start();
        write_byte(8'hA0, ack);
        check("wr_addr_ack", 32'(ack), 32'(ACK));
        check("wr_busy", 32'(busy_o), 32'd1);
        check("wr_rw", 32'(rw_o), 32'd0);
        write_byte(8'hA5, ack);
        check("wr_b0_ack", 32'(ack), 32'(ACK));
        write_byte(8'h3C, ack);
        check("wr_b1_ack", 32'(ack), 32'(ACK));
        i2c_stop();
        repeat (5) @(negedge clk);
        check("wr_rx_count", 32'(rx_seen.size()), 32'd2);
        if (rx_seen.size() == 2) begin
            check("wr_rx0", 32'(rx_seen[0]), 32'hA5);
            check("wr_rx1", 32'(rx_seen[1]), 32'h3C);
        end
        check("wr_valid_cycles", 32'(rx_valid_cycles - snap), 32'd2);
        check("wr_busy_after_stop", 32'(busy_o), 32'd0);
        check("wr_err", 32'(err_pulses), 32'd0);

        // address mismatch 0x51
        snap = busy_cycles;
        rx_seen.delete();
        i2c_start();
        write_byte(8'hA2, ack);
        check("mis_addr_nack", 32'(ack), 32'(NACK));
        write_byte(8'h55, ack);
        check("mis_data_nack", 32'(ack), 32'(NACK));
        i2c_stop();
        repeat (5) @(negedge clk);
        check("mis_busy_cycles", 32'(busy_cycles - snap), 32'd0);
        check("mis_rx_count", 32'(rx_seen.size()), 32'd0);

        // read 0x50: 0x96 (ACK), 0x01 (NACK)
        tx_q.push_back(8'h96);
        tx_q.push_back(8'h01);
        repeat (2) @(negedge clk);
        snap = tx_ready_pulses;
        i2c_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", 32'(ack), 32'(ACK));
        check("rd_rw", 32'(rw_o), 32'd1);
        read_byte(d, ACK);
        check("rd_b0", 32'(d), 32'h96);
        read_byte(d, NACK);
        check("rd_b1", 32'(d), 32'h01);
        check("rd_tx_ready", 32'(tx_ready_pulses - snap), 32'd2);
        check("rd_wait_stop", 32'(dut.state), 32'(WAIT_STOP));
        check("rd_sda_released", 32'(sda_oe_o), 32'd0);
        i2c_stop();
        repeat (5) @(negedge clk);
        check("rd_idle", 32'(dut.state), 32'(IDLE));
        check("rd_busy_clear", 32'(busy_o), 32'd0);
        check("rd_err", 32'(err_pulses), 32'd0);

        // two written bytes with consumer stalled
        rx_ready_i = 1'b0;
        rx_seen.delete();
        snap = err_pulses;
        i2c_start();
        write_byte(8'hA0, ack);
        check("ovr_addr_ack", 32'(ack), 32'(ACK));
        write_byte(8'h11, ack);
        check("ovr_b0_ack", 32'(ack), 32'(ACK));
        check("ovr_b0_valid", 32'(rx_valid_o), 32'd1);
`ifdef I2C_TARGET_CLK_STRETCH_EN
        fork
            write_byte(8'h22, ack);
            begin
                int n;
                n = 0;
                while (!scl_oe_o && n < 4000) begin
                    @(negedge clk);
                    n++;
                end
                check("ovr_stretch", 32'(scl_oe_o), 32'd1);
                repeat (50) @(negedge clk);
                check("ovr_scl_low", 32'(scl_i), 32'd0);
                rx_ready_i = 1'b1;
            end
        join
        check("ovr_b1_ack", 32'(ack), 32'(ACK));
        i2c_stop();
        repeat (5) @(negedge clk);
        check("ovr_rx_count", 32'(rx_seen.size()), 32'd2);
        if (rx_seen.size() == 2) begin
            check("ovr_rx0", 32'(rx_seen[0]), 32'h11);
            check("ovr_rx1", 32'(rx_seen[1]), 32'h22);
        end
        check("ovr_err", 32'(err_pulses - snap), 32'd0);
`else
        write_byte(8'h22, ack);
        check("ovr_b1_nack", 32'(ack), 32'(NACK));
        check("ovr_err", 32'(err_pulses - snap), 32'd1);
        check("ovr_kept", 32'(rx_data_o), 32'h11);
        check("ovr_no_stretch", 32'(scl_oe_o), 32'd0);
        i2c_stop();
        rx_ready_i = 1'b1;
        repeat (5) @(negedge clk);
        check("ovr_rx_count", 32'(rx_seen.size()), 32'd1);
        if (rx_seen.size() == 1) check("ovr_rx0", 32'(rx_seen[0]), 32'h11);
`endif

        // repeated START after one written byte, then read
        rx_ready_i = 1'b0;
        tx_q.push_back(8'h5A);
        repeat (2) @(negedge clk);
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h77, ack);
        check("rs_b0_ack", 32'(ack), 32'(ACK));
        i2c_rstart();
        check("rs_state_addr", 32'(dut.state), 32'(ADDR));
        check("rs_valid_kept", 32'(rx_valid_o), 32'd1);
        check("rs_data_kept", 32'(rx_data_o), 32'h77);
        write_byte(8'hA1, ack);
        check("rs_addr_ack", 32'(ack), 32'(ACK));
        check("rs_rw", 32'(rw_o), 32'd1);
        read_byte(d, NACK);
        check("rs_rd", 32'(d), 32'h5A);
        i2c_stop();
        rx_ready_i = 1'b1;
        repeat (5) @(negedge clk);

        // reset in the middle of a transmit byte
        tx_q.push_back(8'h00);
        repeat (2) @(negedge clk);
        snap = tx_ready_pulses;
        i2c_start();
        write_byte(8'hA1, ack);
        begin
            logic r;
            logic [5:0] tail;
            for (int i = 0; i < 3; i++) scl_bit(1'b1, r);
            check("mr_driving", 32'(sda_oe_o), 32'd1);
            rst = 1'b1;
            @(negedge clk);
            check("mr_sda_release", 32'(sda_oe_o), 32'd0);
            check("mr_busy_clear", 32'(busy_o), 32'd0);
            rst = 1'b0;
            tail = '0;
            for (int i = 0; i < 6; i++) begin
                scl_bit(1'b1, r);
                tail = {tail[4:0], r};
            end
            check("mr_ignored", 32'(tail), 32'h3F);
            check("mr_tx_ready", 32'(tx_ready_pulses - snap), 32'd1);
        end
        i2c_stop();
        rx_seen.delete();
        i2c_start();
        write_byte(8'hA0, ack);
        check("mr_recover_ack", 32'(ack), 32'(ACK));
        write_byte(8'h42, ack);
        i2c_stop();
        repeat (5) @(negedge clk);
        check("mr_recover_rx", 32'(rx_seen.size()), 32'd1);
        if (rx_seen.size() == 1) check("mr_recover_data", 32'(rx_seen[0]), 32'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_target_core.md
I2C_TARGET_CORE -- requirements
Module: i2c_target_core

Interface
REQ-001 Parameters SHALL be:
- TARGET_ADDR, 7'h50, 7-bit address this target responds to.
- SYNC_STAGES, 2, synchronizer depth on scl_i and sda_i (minimum 2).

REQ-002 Ports SHALL be:
- i2c_core_clk_i  in  1  core clock; the only clock; SHALL be at least 10x SCL frequency.
- i2c_core_rst_i  in  1  reset, synchronous, active-high.
- scl_i  in  1  raw SCL pad level.
- sda_i  in  1  raw SDA pad level.
- sda_oe_o  out  1  1 = pull SDA low; 0 = release.
- scl_oe_o  out  1  1 = pull SCL low (clock stretch); 0 = release.
- rx_data_o  out  8  last byte received from the controller.
- rx_valid_o  out  1  rx_data_o holds an unread byte.
- rx_ready_i  in  1  consumer accepts rx_data_o when rx_valid_o=1.
- tx_data_i  in  8  byte to send to the controller.
- tx_valid_i  in  1  tx_data_i is available.
- tx_ready_o  out  1  one-cycle pulse: tx_data_i consumed this cycle.
- busy_o  out  1  addressed transaction in progress.
- rw_o  out  1  R/W bit of the current transaction (1 = controller reads).
- err_o  out  1  one-cycle pulse on RX overrun or TX underrun.

Function
REQ-003 scl_i and sda_i SHALL pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized levels, so latency from pad to event is SYNC_STAGES+1 cycles.
REQ-004 START SHALL be SDA falling while SCL is high; STOP SHALL be SDA rising while SCL is high.
REQ-005 Bits SHALL be sampled on SCL rising edges; sda_oe_o SHALL change only on SCL falling edges (one cycle after detection), never while SCL is high.
REQ-006 The FSM SHALL have the states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK and WAIT_STOP.
REQ-007 IDLE->ADDR on START. ADDR SHALL shift 8 bits MSB first, 7 address bits then R/W.
REQ-008 After the 8th address bit:
- Match with TARGET_ADDR: go to ADDR_ACK, drive ACK (sda_oe_o=1) for the 9th SCL period, set busy_o=1, latch rw_o.
- Mismatch: go to WAIT_STOP with all outputs released.
REQ-009 At the end of ADDR_ACK, go to RX_BYTE if rw_o=0, otherwise to TX_BYTE.
REQ-010 RX_BYTE: after the 8th bit, rx_data_o SHALL load and rx_valid_o SHALL assert in the next cycle, provided rx_valid_o was 0.
- rx_valid_o SHALL clear on the cycle where rx_valid_o & rx_ready_i.
- rx_valid_o and a new load in the same cycle: the load wins.
REQ-011 RX_ACK: ACK if the byte was stored, then return to RX_BYTE. If rx_valid_o was still 1 (overrun), the previous byte SHALL be kept, the new byte dropped, NACK given, err_o pulsed, and the FSM SHALL go to WAIT_STOP.
REQ-012 TX_BYTE entry (the SCL falling edge ending an ACK): if tx_valid_i=1, load the shift register from tx_data_i and pulse tx_ready_o. If tx_valid_i=0 (underrun), send 8'hFF and pulse err_o.
- Bits SHALL be driven MSB first: sda_oe_o = ~bit.
- SDA SHALL be released for the 9th period.
REQ-013 TX_ACK samples the controller on the 9th rising edge: 0 (ACK) -> TX_BYTE; 1 (NACK) -> WAIT_STOP.
REQ-014 A repeated START in any state except IDLE SHALL go to ADDR and release SDA; a pending rx_valid_o SHALL be kept.
REQ-015 STOP in any state SHALL go to IDLE, release sda_oe_o and scl_oe_o, and clear busy_o.

Reset
REQ-016 While i2c_core_rst_i=1 at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL be 0: rx_data_o=8'h00, sda_oe_o, scl_oe_o, rx_valid_o, tx_ready_o, busy_o, rw_o and err_o.
REQ-017 The synchronizers SHALL reset to 1 (idle bus). A reset mid-byte SHALL release the bus on the first reset edge, and the block SHALL ignore the bus until the next START.

Configuration
REQ-018 With I2C_TARGET_CLK_STRETCH_EN defined, the target SHALL stretch the clock instead of reporting errors:
- Overrun: from the SCL falling edge after the 8th bit, scl_oe_o SHALL be 1 until rx_valid_o=0; then store the byte and ACK.
- Underrun: at TX_BYTE entry, scl_oe_o SHALL be 1 until tx_valid_i=1.
- err_o SHALL never pulse.
REQ-019 Without the macro, scl_oe_o SHALL be tied to 0 and REQ-011 and REQ-012 error behaviour SHALL apply.

Structure
REQ-020 Package i2c_pkg SHALL hold the FSM state typedef, the ACK=1'b0 and NACK=1'b1 constants, and the default TARGET_ADDR.
REQ-021 Sub-module i2c_sync_edge (synchronizer plus rise/fall detect) SHALL be instantiated once for SCL and once for SDA.

Verification
REQ-022 Write to 0x50 with data 0xA5, 0x3C, with rx_ready_i=1 -> address ACKed; rx_data_o=0xA5 then 0x3C, each with a 1-cycle rx_valid_o; both bytes ACKed.
REQ-023 Address 0x51 write -> 9th bit NACK (SDA released); no rx_valid_o; busy_o stays 0.
REQ-024 Read from 0x50 with tx_data_i=0x96 then 0x01 and the controller ACKing, then NACKing -> bus carries 0x96, 0x01; two tx_ready_o pulses; WAIT_STOP; IDLE after STOP.
REQ-025 Two written bytes with rx_ready_i=0:
- Macro off -> 2nd byte NACKed, err_o pulses, rx_data_o keeps the 1st byte.
- Macro on -> SCL held low until rx_ready_i=1, then 2nd byte ACKed.
REQ-026 Repeated START after one write byte, then read -> FSM goes to ADDR, rw_o=1.
REQ-027 Reset asserted at the 4th bit of a TX byte -> sda_oe_o=0 on the next edge; no response until a new START.
